// File: rtl/acq_controller.sv
// ---------------------------------------------------------------------------
// acq_controller
//
// Acquisition sequencer for the scope capture RAM. It decimates the incoming
// ADC stream, fills the pre-trigger window, watches for a level/slope trigger
// (or forces one in auto / free-run mode), finishes the post-trigger fill and
// then freezes the buffer until the VGA renderer has drawn a full frame.
// This block owns port A of the capture BRAM. The renderer reads through
// port B, starting at o_rd_base.
//
// Parameters
//   ADDR_W        capture RAM address width, DEPTH = 2**ADDR_W
//   PRE_TRIG      samples kept before the trigger sample (1 .. DEPTH-2)
//   AUTO_TIMEOUT  clocks spent in WAIT_TRIG before a forced trigger (>= 2)
//
// Ports
//   i_clk          capture clock
//   i_rst_n        asynchronous active-low reset
//   i_run          1 = acquire continuously, 0 = stop / abort
//   i_free_run     1 = take the first WAIT_TRIG sample as the trigger
//   i_auto_en      enables the AUTO_TIMEOUT forced trigger
//   i_trig_slope   0 = rising edge, 1 = falling edge
//   i_trig_level   unsigned trigger threshold
//   i_decim        keep 1 of every i_decim+1 valid samples
//   i_sample_valid ADC sample strobe
//   i_sample       unsigned ADC sample
//   i_frame_end    one-cycle pulse at the last line of each VGA frame
//   o_wr_en        port A write enable
//   o_wr_addr      port A address
//   o_wr_data      port A data
//   o_buf_ready    buffer frozen and valid for display
//   o_rd_base      address of the oldest sample in the frozen buffer
//   o_forced       last capture was auto-forced
//   o_state        IDLE=0, ARM=1, WAIT_TRIG=2, POST=3, HOLD=4
// ---------------------------------------------------------------------------
module acq_controller #(
  parameter int ADDR_W       = 14,
  parameter int PRE_TRIG     = 1024,
  parameter int AUTO_TIMEOUT = 2500000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_free_run,
  input  logic              i_auto_en,
  input  logic              i_trig_slope,
  input  logic [7:0]        i_trig_level,
  input  logic [7:0]        i_decim,
  input  logic              i_sample_valid,
  input  logic [7:0]        i_sample,
  input  logic              i_frame_end,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_buf_ready,
  output logic [ADDR_W-1:0] o_rd_base,
  output logic              o_forced,
  output logic [2:0]        o_state
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = $clog2(AUTO_TIMEOUT);

  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] PRE_OFF   = ADDR_W'(PRE_TRIG);
  localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [7:0]        r_dcnt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_pre_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_trig_addr;
  logic [TO_W-1:0]   r_tcnt;
  logic [7:0]        r_prev;
  logic              r_prev_ok;
  logic              r_frame_cnt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic              r_buf_ready;
  logic [ADDR_W-1:0] r_rd_base;
  logic              r_forced;

  logic              w_accept;
  logic              w_active;
  logic              w_abort;
  logic              w_write;
  logic              w_cross;
  logic              w_trig_true;
  logic              w_trig_free;
  logic              w_trig_auto;
  logic              w_trig;
  logic              w_pre_done;
  logic              w_post_done;
  logic              w_hold_exit;
  logic              w_arm_entry;

  // State register. Everything else in the design keys off this.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. Dropping i_run aborts any filling state at once. HOLD
  // ignores i_run until the renderer has finished a whole frame.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (i_run) w_next = S_ARM;
      S_ARM: begin
        if (w_abort)         w_next = S_IDLE;
        else if (w_pre_done) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_abort)     w_next = S_IDLE;
        else if (w_trig) w_next = S_POST;
      end
      S_POST: begin
        if (w_abort)          w_next = S_IDLE;
        else if (w_post_done) w_next = S_HOLD;
      end
      S_HOLD: if (w_hold_exit) w_next = i_run ? S_ARM : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Event decode. A write happens only for an accepted sample in a filling
  // state while i_run is still high, so an abort never leaks a final write.
  // The three trigger sources are decoded separately. o_forced is set only
  // when neither the true trigger nor free-run claimed the sample.
  always_comb begin
    w_accept    = i_sample_valid && (r_dcnt == 8'd0);
    w_active    = (r_state == S_ARM) || (r_state == S_WAIT) || (r_state == S_POST);
    w_abort     = w_active && !i_run;
    w_write     = w_active && i_run && w_accept;
    w_cross     = i_trig_slope ? ((r_prev > i_trig_level) && (i_sample <= i_trig_level))
                               : ((r_prev < i_trig_level) && (i_sample >= i_trig_level));
    w_trig_true = (r_state == S_WAIT) && w_write && r_prev_ok && w_cross;
    w_trig_free = (r_state == S_WAIT) && w_write && i_free_run;
    w_trig_auto = (r_state == S_WAIT) && w_write && i_auto_en && (r_tcnt == TO_MAX);
    w_trig      = w_trig_true || w_trig_free || w_trig_auto;
    w_pre_done  = (r_state == S_ARM) && w_write && (r_pre_cnt == PRE_LAST);
    w_post_done = (r_state == S_POST) && w_write && (r_post_cnt == POST_LAST);
    w_hold_exit = (r_state == S_HOLD) && i_frame_end && r_frame_cnt;
    w_arm_entry = (w_next == S_ARM) && (r_state != S_ARM);
  end

  // Datapath. The decimator counts down between kept samples and starts
  // from zero on every new capture. The timeout counter is cleared outside
  // WAIT_TRIG and saturates, so a forced trigger stays pending until the
  // next accepted sample. rd_base is computed once at the end of the
  // capture so that it is stable for the whole HOLD period.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dcnt      <= '0;
      r_ptr       <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_tcnt      <= '0;
      r_prev      <= '0;
      r_prev_ok   <= 1'b0;
      r_frame_cnt <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_buf_ready <= 1'b0;
      r_rd_base   <= '0;
      r_forced    <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_arm_entry) begin
        r_dcnt <= '0;
      end else if (i_sample_valid) begin
        r_dcnt <= w_accept ? i_decim : (r_dcnt - 8'd1);
      end

      if (r_state != S_WAIT) begin
        r_tcnt <= '0;
      end else if (r_tcnt != TO_MAX) begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      r_wr_en <= w_write;
      if (w_write) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= i_sample;
        r_ptr     <= r_ptr + 1'b1;
        r_prev    <= i_sample;
        r_prev_ok <= 1'b1;
      end

      if (w_arm_entry) begin
        r_ptr     <= '0;
        r_pre_cnt <= '0;
        r_prev_ok <= 1'b0;
      end else if ((r_state == S_ARM) && w_write) begin
        r_pre_cnt <= r_pre_cnt + 1'b1;
      end

      if (w_trig) begin
        r_trig_addr <= r_ptr;
        r_post_cnt  <= ADDR_W'(1);
        r_forced    <= !(w_trig_true || w_trig_free);
      end else if ((r_state == S_POST) && w_write) begin
        r_post_cnt <= r_post_cnt + 1'b1;
      end

      if (w_post_done) begin
        r_buf_ready <= 1'b1;
        r_rd_base   <= r_trig_addr - PRE_OFF;
        r_frame_cnt <= 1'b0;
      end else if ((r_state == S_HOLD) && i_frame_end) begin
        if (w_hold_exit) begin
          r_buf_ready <= 1'b0;
        end else begin
          r_frame_cnt <= 1'b1;
        end
      end
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_buf_ready = r_buf_ready;
  assign o_rd_base   = r_rd_base;
  assign o_forced    = r_forced;
  assign o_state     = r_state;

endmodule
